// File: rtl/mips_mem_pkg.sv
// Shared memory-path definitions for the MIPS datapath: store sizes,
// byte-enable constants and the store aligner state encoding.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } store_size_t;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_ALL  = 4'b1111;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } aligner_state_t;

    // True when a store of the given size cannot be issued at this byte offset
    function automatic logic isMisaligned(input store_size_t size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_lane_packer.sv
// Combinational lane packer: replicates the narrowed store data onto every
// lane and picks the byte enables for the addressed lane(s).
module store_lane_packer
    import mips_mem_pkg::*;
(
    input  store_size_t size,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] laneData,
    output logic        misaligned
);

    // Replicate data per size and select lanes; misaligned stores enable nothing
    always_comb begin
        be         = BE_NONE;
        laneData   = wdata;
        misaligned = isMisaligned(size, offset);
        case (size)
            SZ_BYTE: begin
                laneData = {4{wdata[7:0]}};
                be       = 4'b0001 << offset;
            end
            SZ_HALF: begin
                laneData = {2{wdata[15:0]}};
                be       = offset[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                laneData = wdata;
                be       = BE_ALL;
            end
            default: begin
                laneData = wdata;
                be       = BE_NONE;
            end
        endcase
        if (misaligned) begin
            be = BE_NONE;
        end
    end

endmodule

// File: rtl/store_data_aligner.sv
// Store data aligner: accepts MEM-stage store requests, issues one
// lane-aligned write to data memory per request and rejects misaligned ones.
module store_data_aligner
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [1:0]            size_i,
    output logic                  mem_valid_o,
    input  logic                  mem_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_be_o,
    output logic                  misaligned_o,
    output logic [ADDR_WIDTH-1:0] misaligned_addr_o,
    output logic [CNT_WIDTH-1:0]  store_count_o,
    output logic [CNT_WIDTH-1:0]  misaligned_count_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    aligner_state_t state, stateNext;

    logic [3:0]  packBe;
    logic [31:0] packData;
    logic        packMisaligned;
    logic        acceptReq;
    logic        loadPayload;
    logic        rejectReq;
    logic        handshake;

    store_lane_packer uPacker (
        .size       (store_size_t'(size_i)),
        .offset     (addr_i[1:0]),
        .wdata      (wdata_i),
        .be         (packBe),
        .laneData   (packData),
        .misaligned (packMisaligned)
    );

    // State register; reset abandons any write in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state, ready and per-edge actions; in ISSUE a new request may only
    // enter on the same edge the current write completes
    always_comb begin
        stateNext   = state;
        req_ready_o = 1'b0;
        acceptReq   = 1'b0;
        loadPayload = 1'b0;
        rejectReq   = 1'b0;
        handshake   = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                acceptReq   = req_valid_i;
                if (acceptReq) begin
                    if (packMisaligned) begin
                        rejectReq = 1'b1;
                    end else begin
                        loadPayload = 1'b1;
                        stateNext   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                req_ready_o = mem_ready_i;
                handshake   = mem_ready_i;
                acceptReq   = req_valid_i && mem_ready_i;
                if (handshake) begin
                    stateNext = ST_IDLE;
                    if (acceptReq) begin
                        if (packMisaligned) begin
                            rejectReq = 1'b1;
                        end else begin
                            loadPayload = 1'b1;
                            stateNext   = ST_ISSUE;
                        end
                    end
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    assign mem_valid_o = (state == ST_ISSUE);

    // Write payload is captured on acceptance and held until the next one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            mem_be_o    <= BE_NONE;
        end else if (loadPayload) begin
            mem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_o <= packData;
            mem_be_o    <= packBe;
        end
    end

    // Rejected-store pulse and the address of the last rejected store
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misaligned_o      <= 1'b0;
            misaligned_addr_o <= '0;
        end else begin
            misaligned_o <= rejectReq;
            if (rejectReq) begin
                misaligned_addr_o <= addr_i;
            end
        end
    end

    // Completed and rejected store counters, both wrap silently
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            store_count_o      <= '0;
            misaligned_count_o <= '0;
        end else begin
            if (handshake) begin
                store_count_o <= store_count_o + CNT_ONE;
            end
            if (rejectReq) begin
                misaligned_count_o <= misaligned_count_o + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_store_data_aligner.sv
// Testbench for store_data_aligner: directed steps with a write scoreboard.
module tb_store_data_aligner;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } expWrite_t;

    logic        clk;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        memValid;
    logic        memReady;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memBe;
    logic        misaligned;
    logic [31:0] misalignedAddr;
    logic [15:0] storeCount;
    logic [15:0] misalignedCount;

    int testsRun;
    int testsFailed;
    int validSeen;
    expWrite_t scoreboard[$];

    store_data_aligner #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk                (clk),
        .reset              (reset),
        .req_valid_i        (reqValid),
        .req_ready_o        (reqReady),
        .addr_i             (addr),
        .wdata_i            (wdata),
        .size_i             (size),
        .mem_valid_o        (memValid),
        .mem_ready_i        (memReady),
        .mem_addr_o         (memAddr),
        .mem_wdata_o        (memWdata),
        .mem_be_o           (memBe),
        .misaligned_o       (misaligned),
        .misaligned_addr_o  (misalignedAddr),
        .store_count_o      (storeCount),
        .misaligned_count_o (misalignedCount)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it and reports on mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference lane packing written from the store rules
    function automatic void modelPack(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                      output expWrite_t w, output logic bad);
        bad    = 1'b0;
        w.addr = {a[31:2], 2'b00};
        w.data = d;
        w.be   = 4'b0000;
        if (sz == 2'b00) begin
            w.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
            case (a[1:0])
                2'd0: w.be = 4'b0001;
                2'd1: w.be = 4'b0010;
                2'd2: w.be = 4'b0100;
                default: w.be = 4'b1000;
            endcase
        end else if (sz == 2'b01) begin
            w.data = {d[15:0], d[15:0]};
            if (a[1:0] == 2'd0) w.be = 4'b0011;
            else if (a[1:0] == 2'd2) w.be = 4'b1100;
            else bad = 1'b1;
        end else if (sz == 2'b10) begin
            w.be = 4'b1111;
            bad  = (a[1:0] != 2'd0);
        end else begin
            bad = 1'b1;
        end
    endfunction

    // Drive one request for exactly one clock edge; aligned ones go on the scoreboard
    task automatic applyStimulus(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        expWrite_t w;
        logic bad;
        reqValid = 1'b1;
        size     = sz;
        addr     = a;
        wdata    = d;
        modelPack(sz, a, d, w, bad);
        if (!bad) scoreboard.push_back(w);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    // Scoreboard: compare each completed write against the oldest expected one
    always @(negedge clk) begin
        if (reset && memValid) begin
            validSeen++;
            if (memReady) begin
                if (scoreboard.size() == 0) begin
                    checkOutput("unexpected write", 32'd1, 32'd0);
                end else begin
                    expWrite_t e;
                    e = scoreboard.pop_front();
                    checkOutput("sb addr", memAddr, e.addr);
                    checkOutput("sb data", memWdata, e.data);
                    checkOutput("sb be", {28'd0, memBe}, {28'd0, e.be});
                end
            end
        end
    end

    // Directed sequence
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        validSeen   = 0;
        reset       = 1'b0;
        reqValid    = 1'b0;
        addr        = '0;
        wdata       = '0;
        size        = 2'b00;
        memReady    = 1'b1;

        #1;
        checkOutput("reset mem_valid", {31'd0, memValid}, 32'd0);
        checkOutput("reset mem_be", {28'd0, memBe}, 32'd0);
        checkOutput("reset misaligned", {31'd0, misaligned}, 32'd0);
        checkOutput("reset store_count", {16'd0, storeCount}, 32'd0);
        checkOutput("reset ready", {31'd0, reqReady}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // SB to the top lane
        applyStimulus(2'b00, 32'h1000_0003, 32'h1234_56AB);
        @(negedge clk);
        checkOutput("sb valid", {31'd0, memValid}, 32'd1);
        checkOutput("sb addr", memAddr, 32'h1000_0000);
        checkOutput("sb wdata", memWdata, 32'hABAB_ABAB);
        checkOutput("sb be", {28'd0, memBe}, 32'h8);
        @(negedge clk);
        checkOutput("sb done valid", {31'd0, memValid}, 32'd0);
        checkOutput("sb store_count", {16'd0, storeCount}, 32'd1);

        // SH upper half, then a misaligned SH back-to-back
        applyStimulus(2'b01, 32'h0000_0002, 32'hFFFF_BEEF);
        @(negedge clk);
        checkOutput("sh wdata", memWdata, 32'hBEEF_BEEF);
        checkOutput("sh be", {28'd0, memBe}, 32'hC);
        applyStimulus(2'b01, 32'h0000_0001, 32'h0000_1111);
        @(negedge clk);
        checkOutput("sh mis pulse", {31'd0, misaligned}, 32'd1);
        checkOutput("sh mis addr", misalignedAddr, 32'h0000_0001);
        checkOutput("sh mis no write", {31'd0, memValid}, 32'd0);
        checkOutput("sh mis count", {16'd0, misalignedCount}, 32'd1);
        checkOutput("sh store_count", {16'd0, storeCount}, 32'd2);
        @(negedge clk);
        checkOutput("sh mis pulse end", {31'd0, misaligned}, 32'd0);

        // SW stalled by memory; a request during the stall must be ignored
        memReady = 1'b0;
        applyStimulus(2'b10, 32'h0000_0010, 32'hCAFE_F00D);
        reqValid = 1'b1;
        size     = 2'b10;
        addr     = 32'h0000_0044;
        wdata    = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall valid", {31'd0, memValid}, 32'd1);
            checkOutput("stall addr", memAddr, 32'h0000_0010);
            checkOutput("stall wdata", memWdata, 32'hCAFE_F00D);
            checkOutput("stall ready", {31'd0, reqReady}, 32'd0);
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        memReady = 1'b1;
        #1;
        checkOutput("stall release ready", {31'd0, reqReady}, 32'd1);
        @(negedge clk);
        checkOutput("stall release valid", {31'd0, memValid}, 32'd1);
        @(negedge clk);
        checkOutput("stall done valid", {31'd0, memValid}, 32'd0);
        checkOutput("stall store_count", {16'd0, storeCount}, 32'd3);

        // Four back-to-back SWs at full throughput
        validSeen = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b10, 32'h0000_0100 + 32'(i * 4), 32'hA5A5_0000 + 32'(i));
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("burst valid cycles", 32'(validSeen), 32'd4);
        checkOutput("burst store_count", {16'd0, storeCount}, 32'd7);
        checkOutput("burst done valid", {31'd0, memValid}, 32'd0);

        // Asynchronous reset while a write is stalled
        memReady = 1'b0;
        applyStimulus(2'b00, 32'h0000_0021, 32'h0000_005A);
        @(negedge clk);
        checkOutput("pre-reset valid", {31'd0, memValid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset valid", {31'd0, memValid}, 32'd0);
        checkOutput("async reset store_count", {16'd0, storeCount}, 32'd0);
        checkOutput("async reset mis count", {16'd0, misalignedCount}, 32'd0);
        checkOutput("async reset addr", memAddr, 32'd0);
        checkOutput("async reset wdata", memWdata, 32'd0);
        scoreboard.delete();
        @(posedge clk);
        #1;
        reset    = 1'b1;
        memReady = 1'b1;
        applyStimulus(2'b00, 32'h0000_0021, 32'h0000_005A);
        @(negedge clk);
        checkOutput("post-reset sb wdata", memWdata, 32'h5A5A_5A5A);
        checkOutput("post-reset sb be", {28'd0, memBe}, 32'h2);
        checkOutput("post-reset sb addr", memAddr, 32'h0000_0020);
        @(negedge clk);
        checkOutput("post-reset store_count", {16'd0, storeCount}, 32'd1);

        // Reserved size and misaligned SW are rejected
        applyStimulus(2'b11, 32'h0000_0040, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("rsvd pulse", {31'd0, misaligned}, 32'd1);
        checkOutput("rsvd addr", misalignedAddr, 32'h0000_0040);
        checkOutput("rsvd no write", {31'd0, memValid}, 32'd0);
        checkOutput("rsvd count", {16'd0, misalignedCount}, 32'd1);
        applyStimulus(2'b10, 32'h0000_0042, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("sw mis pulse", {31'd0, misaligned}, 32'd1);
        checkOutput("sw mis addr", misalignedAddr, 32'h0000_0042);
        checkOutput("sw mis count", {16'd0, misalignedCount}, 32'd2);

        // Store counter wrap
        for (int i = 0; i < 65534; i++) begin
            applyStimulus(2'b10, 32'h0000_0200, 32'(i));
        end
        @(negedge clk);
        @(negedge clk);
        checkOutput("count at max", {16'd0, storeCount}, 32'h0000_FFFF);
        applyStimulus(2'b10, 32'h0000_0204, 32'h7777_7777);
        @(negedge clk);
        @(negedge clk);
        checkOutput("count wrap", {16'd0, storeCount}, 32'd0);
        checkOutput("mis count kept", {16'd0, misalignedCount}, 32'd2);
        checkOutput("scoreboard drained", 32'(scoreboard.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/store_data_aligner.md
Name: store_data_aligner

Overview:
- Store-side counterpart of the load-path sign-extend/widen logic in the MIPS datapath.
- Narrows a 32-bit register value to byte/halfword/word, replicates it onto the correct byte lanes, generates byte enables and issues one write to data memory over a valid/ready handshake.
- Sits between the MEM-stage store request and the data memory port; flags misaligned stores instead of issuing them.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- CNT_WIDTH, 16, width of completed-store and misaligned-store counters.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req_valid_i  input  1  store request valid
- req_ready_o  output  1  block can accept a request this cycle
- addr_i  input  ADDR_WIDTH  byte address of the store
- wdata_i  input  32  register data; only the low 8/16/32 bits are used
- size_i  input  2  00 = SB, 01 = SH, 10 = SW, 11 = reserved
- mem_valid_o  output  1  write request to memory
- mem_ready_i  input  1  memory accepts the write
- mem_addr_o  output  ADDR_WIDTH  word-aligned address {addr[ADDR_WIDTH-1:2], 2'b00}
- mem_wdata_o  output  32  lane-replicated data
- mem_be_o  output  4  byte enables; bit i enables byte i (little-endian lanes)
- misaligned_o  output  1  one-cycle pulse: rejected store
- misaligned_addr_o  output  ADDR_WIDTH  address of the last rejected store
- store_count_o  output  CNT_WIDTH  completed stores, wraps at 2^CNT_WIDTH
- misaligned_count_o  output  CNT_WIDTH  rejected stores, wraps

Behaviour:
- Reset (reset == 0, asynchronous):
  - state = IDLE.
  - mem_valid_o = 0; mem_addr_o, mem_wdata_o and mem_be_o = 0.
  - misaligned_o = 0, misaligned_addr_o = 0, both counters = 0.
  - A write already in flight is abandoned; it is not counted.
- Lane packing:
  - SB: data = {4{wdata[7:0]}}, be = 4'b0001 << addr[1:0].
  - SH: data = {2{wdata[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011.
  - SW: data = wdata, be = 4'b1111.
- Misaligned cases: SH with addr[0] = 1, SW with addr[1:0] != 0, and size 11.
- FSM states: IDLE and ISSUE.
- IDLE:
  - req_ready_o = 1.
  - Valid, aligned request accepted at edge N: outputs are registered, mem_valid_o = 1 from cycle N+1, next state ISSUE.
  - Valid, misaligned request accepted at edge N: no memory write. misaligned_o = 1 for cycle N+1 only. misaligned_addr_o = addr_i. misaligned_count_o increments. State stays IDLE.
- ISSUE:
  - mem_valid_o = 1, and mem_addr_o, mem_wdata_o and mem_be_o are held stable until the handshake completes.
  - req_ready_o = mem_ready_i (combinational), which allows back-to-back stores.
  - mem_valid_o && mem_ready_i at an edge: store_count_o increments.
    - If a new aligned request is accepted at the same edge, state stays ISSUE with the new payload and mem_valid_o stays 1.
    - If the new request is misaligned, it is rejected as in IDLE and the next state is IDLE.
    - With no new request, the next state is IDLE and mem_valid_o falls.
  - mem_ready_i low: wait indefinitely, ignore req_valid_i, hold all outputs.
- Throughput and latency:
  - One store per cycle when mem_ready_i is held high.
  - Request-to-mem_valid latency is 1 cycle.
- Counters wrap silently: 0xFFFF + 1 = 0x0000.
- mem_ready_i while mem_valid_o = 0 has no effect.
- Inputs are don't-care when req_valid_i = 0.

Decomposition:
- Package mips_mem_pkg holds:
  - store_size_t enum: SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11.
  - Byte-enable constants BE_NONE and BE_ALL.
  - Shared with the future load-extend unit.
- Sub-module store_lane_packer (combinational):
  - Inputs: size, addr[1:0], wdata.
  - Outputs: be, lane data, misaligned.
  - The top level holds only the FSM, the registers and the counters.

Test Plan:
- SB, addr 0x1000_0003, wdata 0x1234_56AB, mem_ready_i = 1 -> next cycle mem_valid_o = 1, mem_addr_o = 0x1000_0000, mem_wdata_o = 0xABAB_ABAB, mem_be_o = 4'b1000; store_count_o = 1 after the handshake.
- SH, addr 0x0000_0002, wdata 0xFFFF_BEEF -> mem_wdata_o = 0xBEEF_BEEF, mem_be_o = 4'b1100. Then SH at 0x0000_0001 -> misaligned_o pulses one cycle, misaligned_addr_o = 0x0000_0001, no mem_valid_o, misaligned_count_o = 1.
- SW, addr 0x0000_0010, mem_ready_i held 0 for 3 cycles -> mem_valid_o, mem_addr_o and mem_wdata_o stable and req_ready_o = 0 throughout; completes on the cycle mem_ready_i = 1.
- Four consecutive SWs with mem_ready_i = 1 -> mem_valid_o high 4 consecutive cycles with per-cycle payloads, store_count_o = 4.
- reset asserted while in ISSUE with mem_ready_i = 0 -> mem_valid_o drops immediately (async), counters = 0; after release, an SB is accepted normally.
- size_i = 11 -> rejected as misaligned. Preload store_count_o to 0xFFFF via 65535 stores, one more -> 0x0000.
